alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction FIFO depth in entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  FIFO can accept; SHALL equal !full.
REQ-006 in_instr  input  9  fields: [8:6] sel, [5:4] rd_idx, [3:2] rs_idx, [1:0] rt_idx.
REQ-007 halt  input  1  suppresses new issue; the in-flight instruction still completes.
REQ-008 wr_en, wr_addr, wr_data  input  1/2/4  register preload port.
REQ-009 alu_rs, alu_rt  output  4 each  registered operands to the external 4-bit ALU.
REQ-010 alu_sel  output  3  registered opcode to the ALU.
REQ-011 alu_rd  input  4  combinational ALU result; settles within one cycle of the alu_* outputs changing.
REQ-012 result, result_valid  output  4/1  last written-back value; one-cycle strobe.
REQ-013 busy  output  1  SHALL equal (state != IDLE) || !empty.
REQ-014 reg_dump  output  16  {R3,R2,R1,R0}, driven continuously from the register file.

Function
REQ-015 Four 4-bit registers R0..R3 SHALL be held internally.
REQ-016 A push SHALL occur on any edge where in_valid && in_ready; when the FIFO is full, a push SHALL be refused even if a pop occurs on the same edge.
REQ-017 The FSM SHALL have two states: IDLE and EXEC.
REQ-018 IDLE: when !empty && !halt, the block SHALL pop the head on the edge, load alu_sel/alu_rs/alu_rt from R[rs_idx]/R[rt_idx], and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-019 EXEC, on each edge: R[rd_idx] <= alu_rd; result <= alu_rd; result_valid <= 1.
REQ-020 EXEC, same edge, if !empty && !halt: the block SHALL pop and issue the next instruction and stay in EXEC; otherwise it SHALL go to IDLE.
REQ-021 Forwarding: on a back-to-back issue, an operand whose index equals the retiring rd_idx SHALL take alu_rd instead of the stale register value.
REQ-022 Latency: a push at edge N into an empty FIFO in IDLE SHALL give ALU outputs after N+1, writeback at N+2, and result_valid high in cycle N+2..N+3.
REQ-023 Sustained throughput SHALL be one instruction per cycle.
REQ-024 result_valid SHALL be 0 in every cycle not immediately following a writeback edge.
REQ-025 Preload SHALL take effect only when busy==0; otherwise wr_en SHALL be ignored, not queued.
REQ-026 The FIFO pointers SHALL wrap modulo DEPTH, with a separate count or extra pointer bit so that full and empty are distinguishable.
REQ-027 All arithmetic SHALL be 4 bits, modulo 16; compare opcodes (6, 7) SHALL write back their 4-bit code like any other result.
REQ-028 halt asserted while in EXEC SHALL complete the writeback and then go to IDLE with no pop.

Reset
REQ-029 rst SHALL force: state=IDLE; FIFO empty; R0..R3=0; alu_rs=alu_rt=0; alu_sel=0; result=0; result_valid=0.
REQ-030 Reset mid-operation SHALL discard the in-flight instruction and all queued instructions, with no writeback.
REQ-031 in_ready SHALL be 1 and busy 0 in the first cycle after reset release.

Structure
REQ-032 A shared package SHALL hold the opcode constants ADD=0, SUB=1, AND=2, OR=3, ROL=4, ASR=5, EQ=6, GT=7, the instruction field positions, and the state encoding.
REQ-033 The FIFO SHALL be the sub-module instr_fifo (push/pop/full/empty, 9-bit data, parameter DEPTH); the FSM, register file and forwarding logic SHALL stay in the top module.

Verification
REQ-034 Preload R0=3, R1=5, then ADD R2,R0,R1 -> alu_sel=0, alu_rs=3, alu_rt=5; reg_dump[11:8]=8; result=8 with a one-cycle result_valid.
REQ-035 Back-to-back ADD R2,R0,R1 then SUB R3,R2,R0 -> second issue has alu_rs=8 via forwarding; R3=5; two consecutive result_valid cycles.
REQ-036 halt=1, push 5 instructions with DEPTH=4 -> in_ready=0 after 4 pushes and the 5th is refused; release halt -> exactly 4 writebacks in order.
REQ-037 wr_en with R1=9 while busy=1 -> R1 unchanged; the same write with busy=0 -> R1=9 on the next edge.
REQ-038 Assert rst during EXEC with 2 instructions queued -> all registers 0, busy=0, no further result_valid.
REQ-039 Run GT then EQ with R0=7, R1=7 (using the reference ALU codes) -> GT writes back 4'b1010 and EQ writes back 4'b1111.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction fields, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_sequencer_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_EQ  = 3'd6;
    localparam logic [2:0] OP_GT  = 3'd7;

    localparam int INSTR_W = 9;
    localparam int SEL_MSB = 8;
    localparam int SEL_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 2;
    localparam int RT_MSB  = 1;
    localparam int RT_LSB  = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
    } instr_t;

    // Split a raw instruction word into its named fields.
    function automatic instr_t decode(input logic [INSTR_W-1:0] raw);
        instr_t f;
        f.sel = raw[SEL_MSB:SEL_LSB];
        f.rd  = raw[RD_MSB:RD_LSB];
        f.rs  = raw[RS_MSB:RS_LSB];
        f.rt  = raw[RT_MSB:RT_LSB];
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer_instr_fifo.sv
// Instruction queue: DEPTH-entry circular buffer with extra wrap bit on each pointer.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: full refuses pushes (even with a simultaneous pop); pop on empty is ignored.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Pointers match when empty; differ only in the wrap bit when full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer on an accepted push/pop; wrap falls out of the binary increment.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between an accepted push and its pop.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queued instruction sequencer driving an external 4-bit ALU over a 4-entry register file.
// Latency: push->ALU operands 2 edges, writeback 1 edge later; sustains one instruction per cycle.
// Backpressure: in_ready drops when the queue is full; halt stops issue but lets the in-flight op retire.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [8:0]   in_instr,
    input  logic         halt,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [3:0]   wr_data,
    output logic [3:0]   alu_rs,
    output logic [3:0]   alu_rt,
    output logic [2:0]   alu_sel,
    input  logic [3:0]   alu_rd,
    output logic [3:0]   result,
    output logic         result_valid,
    output logic         busy,
    output logic [15:0]  reg_dump
);

    state_t              state_q, state_d;
    logic [3:0]          regs_q [4];
    logic [3:0]          regs_d [4];
    logic [2:0]          alu_sel_q, alu_sel_d;
    logic [3:0]          alu_rs_q, alu_rs_d;
    logic [3:0]          alu_rt_q, alu_rt_d;
    logic [1:0]          rd_q, rd_d;
    logic [3:0]          result_q, result_d;
    logic                result_valid_q, result_valid_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic [INSTR_W-1:0]  head_raw;
    instr_t              head;
    logic                issue;
    logic                retiring;
    logic [3:0]          rs_val;
    logic [3:0]          rt_val;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .din   (in_instr),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head         = decode(head_raw);
    assign issue        = !fifo_empty && !halt;
    assign retiring     = (state_q == ST_EXEC);
    assign in_ready     = !fifo_full;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign alu_sel      = alu_sel_q;
    assign alu_rs       = alu_rs_q;
    assign alu_rt       = alu_rt_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign reg_dump     = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

    // Operand fetch with bypass: the retiring result has not reached the register file yet.
    assign rs_val = (retiring && head.rs == rd_q) ? alu_rd : regs_q[head.rs];
    assign rt_val = (retiring && head.rt == rd_q) ? alu_rd : regs_q[head.rt];

    // Next-state, issue, writeback and preload decisions.
    always_comb begin
        state_d        = state_q;
        regs_d         = regs_q;
        alu_sel_d      = alu_sel_q;
        alu_rs_d       = alu_rs_q;
        alu_rt_d       = alu_rt_q;
        rd_d           = rd_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        fifo_pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                regs_d[rd_q]   = alu_rd;
                result_d       = alu_rd;
                result_valid_d = 1'b1;
                if (issue) fifo_pop = 1'b1;
                else       state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_pop) begin
            alu_sel_d = head.sel;
            alu_rs_d  = rs_val;
            alu_rt_d  = rt_val;
            rd_d      = head.rd;
        end

        // Preload is only honoured while nothing is queued or executing, so it never races a writeback.
        if (wr_en && !busy) regs_d[wr_addr] = wr_data;
    end

    // State, register file and ALU/result registers; reset drops all in-flight work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            for (int i = 0; i < 4; i++) regs_q[i] <= 4'd0;
            alu_sel_q      <= OP_ADD;
            alu_rs_q       <= 4'd0;
            alu_rt_q       <= 4'd0;
            rd_q           <= 2'd0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            regs_q         <= regs_d;
            alu_sel_q      <= alu_sel_d;
            alu_rs_q       <= alu_rs_d;
            alu_rt_q       <= alu_rt_d;
            rd_q           <= rd_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 4-bit ALU attached.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_instr;
    logic        halt;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [3:0]  alu_rs;
    logic [3:0]  alu_rt;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_rd;
    logic [3:0]  result;
    logic        result_valid;
    logic        busy;
    logic [15:0] reg_dump;

    int errors = 0;
    int checks = 0;

    alu_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .halt         (halt),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .alu_rs       (alu_rs),
        .alu_rt       (alu_rt),
        .alu_sel      (alu_sel),
        .alu_rd       (alu_rd),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .reg_dump     (reg_dump)
    );

    always #5 clk = ~clk;

    // Reference ALU: compares return 4'b1111 when true, 4'b1010 when false.
    function automatic logic [3:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ROL:  return {a[2:0], a[3]};
            OP_ASR:  return {a[3], a[3:1]};
            OP_EQ:   return (a == b) ? 4'b1111 : 4'b1010;
            default: return (a > b)  ? 4'b1111 : 4'b1010;
        endcase
    endfunction

    assign alu_rd = alu_ref(alu_sel, alu_rs, alu_rt);

    function automatic logic [8:0] mk(input logic [2:0] s, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
        return {s, d, a, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [10];
    logic [3:0] got [4];
    logic [3:0] mregs [4];
    logic [8:0] q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [8:0] ins;
        logic [3:0] e;

        vecs[0] = '{OP_ADD, 4'd3,  4'd5,  4'd8};
        vecs[1] = '{OP_SUB, 4'd3,  4'd5,  4'd14};
        vecs[2] = '{OP_AND, 4'd12, 4'd10, 4'd8};
        vecs[3] = '{OP_OR,  4'd12, 4'd10, 4'd14};
        vecs[4] = '{OP_ROL, 4'd9,  4'd0,  4'd3};
        vecs[5] = '{OP_ASR, 4'd9,  4'd0,  4'd12};
        vecs[6] = '{OP_EQ,  4'd7,  4'd7,  4'b1111};
        vecs[7] = '{OP_GT,  4'd7,  4'd7,  4'b1010};
        vecs[8] = '{OP_GT,  4'd8,  4'd3,  4'b1111};
        vecs[9] = '{OP_ADD, 4'd15, 4'd1,  4'd0};

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; halt = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state, first cycle after release.
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_reg_dump", reg_dump, 0);
        check("rst_alu_ops", {alu_sel, alu_rs, alu_rt}, 0);

        // Single-op vectors with latency checks: preload R0/R1, run op R2 = R0 op R1.
        for (int i = 0; i < 10; i++) begin
            preload(2'd0, vecs[i].a);
            preload(2'd1, vecs[i].b);
            in_valid = 1'b1;
            in_instr = mk(vecs[i].sel, 2'd2, 2'd0, 2'd1);
            tick();
            in_valid = 1'b0;
            check("vec_no_early_rv", result_valid, 0);
            tick();
            check("vec_alu_issue", {alu_sel, alu_rs, alu_rt}, {vecs[i].sel, vecs[i].a, vecs[i].b});
            check("vec_no_rv_at_issue", result_valid, 0);
            tick();
            check("vec_rv", result_valid, 1);
            check("vec_result", result, vecs[i].exp);
            check("vec_r2", reg_dump[11:8], vecs[i].exp);
            tick();
            check("vec_rv_drop", result_valid, 0);
        end

        // Back-to-back issue with forwarding: ADD R2,R0,R1 then SUB R3,R2,R0.
        preload(2'd0, 4'd3);
        preload(2'd1, 4'd5);
        halt = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(OP_ADD, 2'd2, 2'd0, 2'd1); tick();
        in_instr = mk(OP_SUB, 2'd3, 2'd2, 2'd0); tick();
        in_valid = 1'b0;
        halt = 1'b0;
        tick();
        check("b2b_issue1", {alu_sel, alu_rs, alu_rt}, {OP_ADD, 4'd3, 4'd5});
        tick();
        check("b2b_issue2_fwd", {alu_sel, alu_rs, alu_rt}, {OP_SUB, 4'd8, 4'd3});
        check("b2b_rv1", {result_valid, result}, {1'b1, 4'd8});
        tick();
        check("b2b_rv2", {result_valid, result}, {1'b1, 4'd5});
        check("b2b_r3", reg_dump[15:12], 5);
        tick();
        check("b2b_rv_drop", result_valid, 0);

        // Fill under halt: four accepted, fifth refused; drain in order.
        preload(2'd0, 4'd1);
        preload(2'd1, 4'd2);
        halt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            case (k)
                0: in_instr = mk(OP_ADD, 2'd2, 2'd0, 2'd1);
                1: in_instr = mk(OP_ADD, 2'd3, 2'd2, 2'd1);
                2: in_instr = mk(OP_ADD, 2'd2, 2'd3, 2'd0);
                3: in_instr = mk(OP_SUB, 2'd3, 2'd2, 2'd1);
                default: in_instr = mk(OP_OR, 2'd0, 2'd1, 2'd1);
            endcase
            check("full_in_ready", in_ready, (k < 4) ? 1 : 0);
            tick();
        end
        in_valid = 1'b0;
        check("full_busy_halted", busy, 1);
        halt = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (result_valid) begin
                if (n < 4) got[n] = result;
                n++;
            end
        end
        check("full_wb_count", n[15:0], 4);
        check("full_wb0", got[0], 3);
        check("full_wb1", got[1], 5);
        check("full_wb2", got[2], 6);
        check("full_wb3", got[3], 4);
        check("full_regs", reg_dump, 16'h4621);

        // Preload ignored while busy, honoured once idle.
        halt = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(OP_ADD, 2'd3, 2'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        preload(2'd1, 4'd9);
        check("wr_busy_ignored", reg_dump[7:4], 2);
        halt = 1'b0;
        n = 0;
        while (busy && n < 10) begin tick(); n++; end
        check("wr_idle_reached", busy, 0);
        check("wr_busy_not_queued", reg_dump[7:4], 2);
        preload(2'd1, 4'd9);
        check("wr_idle_applied", reg_dump[7:4], 9);

        // Reset during EXEC with two queued instructions.
        halt = 1'b1;
        in_valid = 1'b1;
        in_instr = mk(OP_ADD, 2'd0, 2'd1, 2'd1); tick();
        in_instr = mk(OP_ADD, 2'd2, 2'd1, 2'd1); tick();
        in_instr = mk(OP_ADD, 2'd3, 2'd1, 2'd1); tick();
        in_valid = 1'b0;
        halt = 1'b0;
        tick();
        check("rstmid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_regs", reg_dump, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_rv", result_valid, 0);
        tick();
        rst = 1'b0;
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_busy_release", busy, 0);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (result_valid) n++;
        end
        check("rstmid_no_rv", n[15:0], 0);
        check("rstmid_regs_after", reg_dump, 0);

        // Randomised traffic against an architectural model (program-order register file).
        for (int a = 0; a < 4; a++) begin
            mregs[a] = 4'($urandom_range(0, 15));
            preload(a[1:0], mregs[a]);
        end
        for (int c = 0; c < 460; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = 9'($urandom_range(0, 511));
            halt     = ($urandom_range(0, 4) == 0);
            if (c >= 400) begin in_valid = 1'b0; halt = 1'b0; end
            if (in_valid && in_ready) q.push_back(in_instr);
            tick();
            if (result_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious_rv: got result_valid=1, expected 0 with nothing pending");
                end else begin
                    ins = q.pop_front();
                    e = alu_ref(ins[8:6], mregs[ins[3:2]], mregs[ins[1:0]]);
                    mregs[ins[5:4]] = e;
                    check("rand_result", result, e);
                end
            end
        end
        check("rand_pending", q.size(), 0);
        check("rand_busy", busy, 0);
        check("rand_regs", reg_dump, {mregs[3], mregs[2], mregs[1], mregs[0]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
